// File: rtl/noc_pkg.sv
// Shared definitions for the NoC source interface and the mesh router:
// head-flit layout, packetizer states and the flit bundle.
package noc_pkg;

    localparam int TAG_LSB  = 0;
    localparam int LEN_LSB  = 8;
    localparam int SRC_LSB  = 16;
    localparam int DEST_LSB = 24;

    // Default build widths of the flit bundle exchanged with the router
    localparam int FLIT_W_DEF = 64;
    localparam int DEST_W_DEF = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } pkt_state_e;

    typedef struct packed {
        logic [FLIT_W_DEF-1:0] data;
        logic                  valid;
        logic                  last;
        logic [DEST_W_DEF-1:0] dest;
    } flit_t;

    function automatic int dest_w(input int nodes);
        return (nodes > 1) ? $clog2(nodes) : 1;
    endfunction

endpackage

// File: rtl/noc_packetizer_if.sv
// Message-in / flit-out bundle of one packetizer; the slave modport is the
// packetizer itself, the master modport is the attached node plus router.
interface noc_packetizer_if
    import noc_pkg::*;
#(
    parameter int NODES      = 6,
    parameter int FLIT_WIDTH = 64,
    parameter int MAX_BEATS  = 16,
    parameter int CREDITS    = 4
);
    localparam int DEST_W = dest_w(NODES);
    localparam int LEN_W  = $clog2(MAX_BEATS + 1);
    localparam int CW     = $clog2(CREDITS + 1);

    logic                  hdr_valid;
    logic                  hdr_ready;
    logic [DEST_W-1:0]     hdr_dest;
    logic [LEN_W-1:0]      hdr_len;
    logic [7:0]            hdr_tag;
    logic                  pl_valid;
    logic                  pl_ready;
    logic [FLIT_WIDTH-1:0] pl_data;
    logic                  flit_valid;
    logic [FLIT_WIDTH-1:0] flit_data;
    logic                  flit_last;
    logic [DEST_W-1:0]     flit_dest;
    logic                  credit_return;
    logic [CW-1:0]         credit_count;
    logic                  err_len;
    logic                  err_credit;
    logic                  busy;

    modport slave (
        input  hdr_valid, hdr_dest, hdr_len, hdr_tag,
        output hdr_ready,
        input  pl_valid, pl_data,
        output pl_ready,
        output flit_valid, flit_data, flit_last, flit_dest,
        input  credit_return,
        output credit_count, err_len, err_credit, busy
    );

    modport master (
        output hdr_valid, hdr_dest, hdr_len, hdr_tag,
        input  hdr_ready,
        output pl_valid, pl_data,
        input  pl_ready,
        input  flit_valid, flit_data, flit_last, flit_dest,
        output credit_return,
        input  credit_count, err_len, err_credit, busy
    );

endinterface

// File: rtl/noc_credit_counter.sv
// Credit counter for one downstream buffer: starts full, consume takes a
// credit, credit_return gives one back; an overflowing return is flagged.
module noc_credit_counter #(
    parameter  int CREDITS = 4,
    localparam int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          consume,
    input  logic          credit_return,
    output logic [CW-1:0] count,
    output logic          nonzero,
    output logic          err_credit
);

    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    always_comb begin
        count_d = count_q;
        err_d   = 1'b0;
        // A simultaneous consume and return cancel out
        unique case ({consume, credit_return})
            2'b10: begin
                if (count_q != '0) count_d = count_q - CW'(1);
            end
            2'b01: begin
                if (count_q == FULL) err_d = 1'b1;
                else                 count_d = count_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= FULL;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count      = count_q;
    assign nonzero    = (count_q != '0);
    assign err_credit = err_q;

endmodule

// File: rtl/noc_packetizer.sv
// Source-side network interface: turns a header plus payload words into a
// head flit and body flits, paced by credits from the router input buffer.
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int NODES      = 6,
    parameter int FLIT_WIDTH = 64,
    parameter int SRC_ID     = 0,
    parameter int MAX_BEATS  = 16,
    parameter int CREDITS    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    noc_packetizer_if.slave bus
);

    localparam int DEST_W = dest_w(NODES);
    localparam int LEN_W  = $clog2(MAX_BEATS + 1);
    localparam int CW     = $clog2(CREDITS + 1);

    function automatic logic [FLIT_WIDTH-1:0] head_flit(
        input logic [7:0]        tag,
        input logic [LEN_W-1:0]  len,
        input logic [DEST_W-1:0] dest
    );
        logic [FLIT_WIDTH-1:0] f;
        f                 = '0;
        f[TAG_LSB  +: 8]  = tag;
        f[LEN_LSB  +: 8]  = 8'(len);
        f[SRC_LSB  +: 8]  = 8'(SRC_ID);
        f[DEST_LSB +: 8]  = 8'(dest);
        return f;
    endfunction

    pkt_state_e            state_q, state_d;
    logic [LEN_W-1:0]      beats_left_q, beats_left_d;
    logic                  flit_valid_q, flit_valid_d;
    logic                  flit_last_q, flit_last_d;
    logic [FLIT_WIDTH-1:0] flit_data_q, flit_data_d;
    logic [DEST_W-1:0]     flit_dest_q, flit_dest_d;
    logic                  err_len_q, err_len_d;

    logic          credits_nz;
    logic [CW-1:0] credit_count;
    logic          err_credit;
    logic          hdr_fire, pl_fire, len_bad, hdr_ok, consume;

    assign bus.hdr_ready = (state_q == IDLE) && credits_nz;
    assign bus.pl_ready  = (state_q == BODY) && credits_nz;

    assign hdr_fire = bus.hdr_valid && bus.hdr_ready;
    assign pl_fire  = bus.pl_valid && bus.pl_ready;
    assign len_bad  = bus.hdr_len > LEN_W'(MAX_BEATS);
    assign hdr_ok   = hdr_fire && !len_bad;
    // Rejected headers never reach the router, so they cost no credit
    assign consume  = hdr_ok || pl_fire;

    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        flit_valid_d = 1'b0;
        flit_last_d  = flit_last_q;
        flit_data_d  = flit_data_q;
        flit_dest_d  = flit_dest_q;
        err_len_d    = hdr_fire && len_bad;

        if (hdr_ok) begin
            flit_valid_d = 1'b1;
            flit_data_d  = head_flit(bus.hdr_tag, bus.hdr_len, bus.hdr_dest);
            flit_last_d  = (bus.hdr_len == '0);
            flit_dest_d  = bus.hdr_dest;
            if (bus.hdr_len != '0) begin
                state_d      = BODY;
                beats_left_d = bus.hdr_len;
            end
        end

        if (pl_fire) begin
            flit_valid_d = 1'b1;
            flit_data_d  = bus.pl_data;
            flit_last_d  = (beats_left_q == LEN_W'(1));
            beats_left_d = beats_left_q - LEN_W'(1);
            if (beats_left_q == LEN_W'(1)) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            flit_valid_q <= 1'b0;
            flit_last_q  <= 1'b0;
            flit_data_q  <= '0;
            flit_dest_q  <= '0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            flit_valid_q <= flit_valid_d;
            flit_last_q  <= flit_last_d;
            flit_data_q  <= flit_data_d;
            flit_dest_q  <= flit_dest_d;
            err_len_q    <= err_len_d;
        end
    end

    noc_credit_counter #(
        .CREDITS(CREDITS)
    ) u_credits (
        .clk          (clk),
        .rst_n        (rst_n),
        .consume      (consume),
        .credit_return(bus.credit_return),
        .count        (credit_count),
        .nonzero      (credits_nz),
        .err_credit   (err_credit)
    );

    assign bus.flit_valid   = flit_valid_q;
    assign bus.flit_data    = flit_data_q;
    assign bus.flit_last    = flit_last_q;
    assign bus.flit_dest    = flit_dest_q;
    assign bus.credit_count = credit_count;
    assign bus.err_len      = err_len_q;
    assign bus.err_credit   = err_credit;
    assign bus.busy         = (state_q != IDLE);

endmodule
